// File: rtl/cpu_alu_exec.sv
// ---------------------------------------------------------------------------
// cpu_alu_exec
//   Execute unit for the CHIP-8 register/ALU/skip opcodes. It takes one 16-bit
//   opcode per op_valid/op_ready handshake. It reads Vx/Vy through x_sel/y_sel
//   and issues the Vx and VF writes. It then pulses pc_inc for the normal
//   advance or the skip advance.
//
//   Optional build macro:
//     CHIP8_SHIFT_VY_EN  defined: 8xy6/8xyE shift Vy (COSMAC semantics)
//                        undefined: shifts operate on Vx, y is ignored
//
//   Parameters:
//     PC_STEP   pc_inc pulses per normal advance (a skip advance is 2*PC_STEP)
//
//   Ports:
//     clk       system clock, rising edge
//     rst       asynchronous active-low reset
//     op_valid  opcode offered
//     opcode    CHIP-8 instruction word
//     op_ready  unit idle, will accept an opcode
//     done      one-cycle pulse when the instruction retires
//     illegal   one-cycle pulse with done for an unsupported opcode
//     x_sel     register file x select (latched opcode[11:8])
//     y_sel     register file y select (latched opcode[7:4])
//     vx_in     Vx read data (combinational from register file)
//     vy_in     Vy read data
//     wx / nx   Vx write enable / data
//     wf / nf   VF write enable / data
//     pc_inc    PC increment pulse, one per asserted cycle
// ---------------------------------------------------------------------------
module cpu_alu_exec #(
    parameter int PC_STEP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [15:0] opcode,
    output logic        op_ready,
    output logic        done,
    output logic        illegal,
    output logic [3:0]  x_sel,
    output logic [3:0]  y_sel,
    input  logic [7:0]  vx_in,
    input  logic [7:0]  vy_in,
    output logic        wx,
    output logic [7:0]  nx,
    output logic        wf,
    output logic [7:0]  nf,
    output logic        pc_inc
);

    localparam int CNT_W = $clog2(2 * PC_STEP + 1);

    typedef enum logic [1:0] {IDLE, EXEC, STEP, DONE} state_t;

    typedef struct packed {
        logic       wx;
        logic [7:0] nx;
        logic       wf;
        logic [7:0] nf;
        logic       skip;
        logic       illegal;
    } exec_t;

    state_t           state;
    logic [15:0]      op_q;
    logic [CNT_W-1:0] step_cnt;
    logic             ill_q;
    exec_t            res;

    // Decode and evaluate one opcode against the current operands. Every flag
    // result uses the operands as read before any write lands, so x==F works.
    function automatic exec_t exec_op(input logic [15:0] op,
                                      input logic [7:0]  vx,
                                      input logic [7:0]  vy);
        exec_t      r;
        logic [8:0] sum;
        logic [7:0] src;
        r   = '0;
        sum = {1'b0, vx} + {1'b0, vy};
`ifdef CHIP8_SHIFT_VY_EN
        src = vy;
`else
        src = vx;
`endif
        case (op[15:12])
            4'h3: r.skip = (vx == op[7:0]);
            4'h4: r.skip = (vx != op[7:0]);
            4'h5: begin
                if (op[3:0] == 4'h0) r.skip = (vx == vy);
                else                 r.illegal = 1'b1;
            end
            4'h9: begin
                if (op[3:0] == 4'h0) r.skip = (vx != vy);
                else                 r.illegal = 1'b1;
            end
            4'h6: begin
                r.wx = 1'b1;
                r.nx = op[7:0];
            end
            4'h7: begin
                r.wx = 1'b1;
                r.nx = vx + op[7:0];
            end
            4'h8: begin
                r.wx = 1'b1;
                case (op[3:0])
                    4'h0: r.nx = vy;
                    4'h1: r.nx = vx | vy;
                    4'h2: r.nx = vx & vy;
                    4'h3: r.nx = vx ^ vy;
                    4'h4: begin
                        r.nx = sum[7:0];
                        r.wf = 1'b1;
                        r.nf = {7'd0, sum[8]};
                    end
                    4'h5: begin
                        r.nx = vx - vy;
                        r.wf = 1'b1;
                        r.nf = {7'd0, (vx >= vy)};
                    end
                    4'h7: begin
                        r.nx = vy - vx;
                        r.wf = 1'b1;
                        r.nf = {7'd0, (vy >= vx)};
                    end
                    4'h6: begin
                        r.nx = {1'b0, src[7:1]};
                        r.wf = 1'b1;
                        r.nf = {7'd0, src[0]};
                    end
                    4'hE: begin
                        r.nx = {src[6:0], 1'b0};
                        r.wf = 1'b1;
                        r.nf = {7'd0, src[7]};
                    end
                    default: begin
                        r.wx      = 1'b0;
                        r.illegal = 1'b1;
                    end
                endcase
            end
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

    assign x_sel = op_q[11:8];
    assign y_sel = op_q[7:4];
    assign res   = exec_op(op_q, vx_in, vy_in);

    // Writes exist only in EXEC; the data buses are held at zero otherwise.
    assign wx       = (state == EXEC) && res.wx;
    assign wf       = (state == EXEC) && res.wf;
    assign nx       = wx ? res.nx : 8'h00;
    assign nf       = wf ? res.nf : 8'h00;
    assign pc_inc   = (state == STEP);
    assign done     = (state == DONE);
    assign illegal  = (state == DONE) && ill_q;
    assign op_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            op_q     <= 16'h0000;
            step_cnt <= '0;
            ill_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        op_q  <= opcode;
                        ill_q <= 1'b0;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (res.illegal) begin
                        ill_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        // Counter holds remaining pc_inc cycles minus one.
                        step_cnt <= res.skip ? CNT_W'(2 * PC_STEP - 1)
                                             : CNT_W'(PC_STEP - 1);
                        state    <= STEP;
                    end
                end
                STEP: begin
                    if (step_cnt == '0) state <= DONE;
                    else                step_cnt <= step_cnt - 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_alu_exec.sv
module tb_cpu_alu_exec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [15:0] opcode = 16'h0000;
    logic        op_ready, done, illegal, wx, wf, pc_inc;
    logic [3:0]  x_sel, y_sel;
    logic [7:0]  vx_in, vy_in, nx, nf;

    // Register file model: wf applied after wx, so VF keeps the flag.
    logic [7:0]  rf [16];
    logic        ld_en = 1'b0;
    logic [3:0]  ld_idx = 4'd0;
    logic [7:0]  ld_val = 8'd0;

    int checks = 0;
    int failures = 0;

    // Per-instruction observations
    int          cyc, pc_cnt, first_pc, last_pc, done_cyc, wx_cyc;
    logic        got_wx, got_wf, got_ill, rdy_after;
    logic [7:0]  got_nx, got_nf;

    always #5 clk = ~clk;

    cpu_alu_exec #(.PC_STEP(2)) dut (
        .clk(clk), .rst(rst_n), .op_valid(op_valid), .opcode(opcode),
        .op_ready(op_ready), .done(done), .illegal(illegal),
        .x_sel(x_sel), .y_sel(y_sel), .vx_in(vx_in), .vy_in(vy_in),
        .wx(wx), .nx(nx), .wf(wf), .nf(nf), .pc_inc(pc_inc)
    );

    assign vx_in = rf[x_sel];
    assign vy_in = rf[y_sel];

    always @(posedge clk) begin
        if (ld_en) rf[ld_idx] <= ld_val;
        if (wx) rf[x_sel] <= nx;
        if (wf) rf[15] <= nf;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_reg(input logic [3:0] idx, input logic [7:0] val);
        @(negedge clk);
        ld_en = 1'b1; ld_idx = idx; ld_val = val;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Issue one opcode and record what happens, cycle 1 = EXEC cycle.
    task automatic run_op(input logic [15:0] op);
        @(negedge clk);
        op_valid = 1'b1; opcode = op;
        @(negedge clk);
        op_valid = 1'b0;
        cyc = 1; pc_cnt = 0; first_pc = 0; last_pc = 0; done_cyc = 0; wx_cyc = 0;
        got_wx = 0; got_wf = 0; got_ill = 0; got_nx = 0; got_nf = 0;
        while (done_cyc == 0 && cyc < 30) begin
            if (wx) begin got_wx = 1; got_nx = nx; wx_cyc = cyc; end
            if (wf) begin got_wf = 1; got_nf = nf; end
            if (pc_inc) begin
                pc_cnt++;
                if (first_pc == 0) first_pc = cyc;
                last_pc = cyc;
            end
            if (done) begin done_cyc = cyc; got_ill = illegal; end
            @(negedge clk);
            cyc++;
        end
        rdy_after = op_ready;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 8'h00;
        repeat (2) @(negedge clk);
        // Reset state
        chk("rst_op_ready", op_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_pc_inc", pc_inc, 0);
        chk("rst_wx_wf", {wx, wf}, 0);
        chk("rst_nx_nf", {nx, nf}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: 8344 add with carry
        set_reg(3, 8'hF0); set_reg(4, 8'h20);
        run_op(16'h8344);
        chk("t1_wx", got_wx, 1);
        chk("t1_wx_cyc", wx_cyc, 1);
        chk("t1_nx", got_nx, 8'h10);
        chk("t1_wf_nf", {got_wf, got_nf}, {1'b1, 8'h01});
        chk("t1_pc_cnt", pc_cnt, 2);
        chk("t1_pc_first", first_pc, 2);
        chk("t1_done_cyc", done_cyc, 4);
        chk("t1_ready_after", rdy_after, 1);
        chk("t1_ill", got_ill, 0);

        // 2: subtract both ways
        set_reg(1, 8'h05); set_reg(2, 8'h07);
        run_op(16'h8125);
        chk("t2_sub_nx", got_nx, 8'hFE);
        chk("t2_sub_nf", {got_wf, got_nf}, {1'b1, 8'h00});
        set_reg(1, 8'h05); set_reg(2, 8'h07);
        run_op(16'h8127);
        chk("t2_subn_nx", got_nx, 8'h02);
        chk("t2_subn_nf", {got_wf, got_nf}, {1'b1, 8'h01});

        // 3: skips
        set_reg(5, 8'h42);
        run_op(16'h3542);
        chk("t3_skip_writes", {got_wx, got_wf}, 0);
        chk("t3_skip_pc", pc_cnt, 4);
        chk("t3_skip_span", last_pc - first_pc, 3);
        chk("t3_skip_done", done_cyc, 6);
        run_op(16'h3543);
        chk("t3_noskip_pc", pc_cnt, 2);
        run_op(16'h4543);
        chk("t3_sne_pc", pc_cnt, 4);
        set_reg(6, 8'h42);
        run_op(16'h5560);
        chk("t3_se_xy_pc", pc_cnt, 4);
        run_op(16'h9560);
        chk("t3_sne_xy_pc", pc_cnt, 2);

        // 4: x==F flag wins
        set_reg(15, 8'h01); set_reg(0, 8'hFF);
        run_op(16'h8F04);
        chk("t4_nx", {got_wx, got_nx}, {1'b1, 8'h00});
        chk("t4_nf", {got_wf, got_nf}, {1'b1, 8'h01});
        chk("t4_vf", rf[15], 8'h01);

        // Other ALU ops
        set_reg(1, 8'hF0);
        run_op(16'h7120);
        chk("add_imm_nx", got_nx, 8'h10);
        chk("add_imm_nowf", got_wf, 0);
        set_reg(2, 8'h3C);
        run_op(16'h8122);
        chk("and_nx", got_nx, 8'h10);
        run_op(16'h6A5B);
        chk("ld_imm_reg", rf[10], 8'h5B);

        // 5: reset in first pc_inc cycle
        @(negedge clk);
        op_valid = 1'b1; opcode = 16'h6C11;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        pc_cnt = pc_inc ? 1 : 0;
        rst_n = 1'b0;
        #1;
        chk("t5_pc_drop", pc_inc, 0);
        got_ill = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (pc_inc) pc_cnt++;
            if (done) got_ill = 1;
        end
        chk("t5_pc_total", pc_cnt, 1);
        chk("t5_no_done", got_ill, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_ready", op_ready, 1);

        // 6: shifts and illegal
        set_reg(6, 8'h81); set_reg(7, 8'h02);
        run_op(16'h8676);
`ifdef CHIP8_SHIFT_VY_EN
        chk("t6_shr", {got_nx, got_nf}, {8'h01, 8'h00});
`else
        chk("t6_shr", {got_nx, got_nf}, {8'h40, 8'h01});
`endif
        set_reg(6, 8'h81);
        run_op(16'h867E);
`ifdef CHIP8_SHIFT_VY_EN
        chk("t6_shl", {got_nx, got_nf}, {8'h04, 8'h00});
`else
        chk("t6_shl", {got_nx, got_nf}, {8'h02, 8'h01});
`endif
        run_op(16'hF000);
        chk("t6_ill", got_ill, 1);
        chk("t6_ill_done", done_cyc, 2);
        chk("t6_ill_pc", pc_cnt, 0);
        chk("t6_ill_writes", {got_wx, got_wf}, 0);
        run_op(16'h5121);
        chk("ill_5xyN", {got_ill, 8'(pc_cnt)}, {1'b1, 8'h00});
        run_op(16'h8128);
        chk("ill_8xy8", {got_ill, got_wx}, {1'b1, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
